cache_mem_ctrl: RTL and testbench

//  Responder side of the cache<->memory handshake. Serves icache (iREN) and dcache (dREN/dWEN)

---
 rtl/cache_mem_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cache_mem_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_ctrl.sv
// Arbitrates per-core icache/dcache requests onto a single RAM port: data before instruction, round-robin among cores.
// Optional feature macro ARB_STATS_EN adds per-core completed-transfer counters (grant_cnt) and an ERROR-cycle counter (err_cnt).
module cache_mem_ctrl #(
  parameter int NCPU   = 2,
  parameter int WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NCPU-1:0]        iREN,
  input  logic [NCPU*WORD_W-1:0] iaddr,
  input  logic [NCPU-1:0]        dREN,
  input  logic [NCPU-1:0]        dWEN,
  input  logic [NCPU*WORD_W-1:0] daddr,
  input  logic [NCPU*WORD_W-1:0] dstore,
  output logic [NCPU-1:0]        iwait,
  output logic [NCPU-1:0]        dwait,
  output logic [NCPU*WORD_W-1:0] iload,
  output logic [NCPU*WORD_W-1:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
`ifdef ARB_STATS_EN
  output logic [NCPU*16-1:0]     grant_cnt,
  output logic [15:0]            err_cnt,
`endif
  input  logic [1:0]             ramstate
);

  localparam int CW = (NCPU > 1) ? $clog2(NCPU) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   gnt_cpu_q, gnt_cpu_d;
  logic            gnt_data_q, gnt_data_d;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NCPU-1:0] dreq;
  logic            live_req;
  logic            is_write;

  assign dreq = dREN | dWEN;

  // First requester at or after ptr, wrapping around the cores.
  function automatic logic [CW-1:0] rr_pick(input logic [NCPU-1:0] req, input logic [CW-1:0] ptr);
    logic [CW-1:0] pick;
    logic [CW-1:0] idx;
    pick = ptr;
    for (int k = NCPU - 1; k >= 0; k--) begin
      idx = CW'((int'(ptr) + k) % NCPU);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  always_comb begin
    state_d    = state_q;
    gnt_cpu_d  = gnt_cpu_q;
    gnt_data_d = gnt_data_q;
    rr_ptr_d   = rr_ptr_q;
    iwait      = '1;
    dwait      = '1;
    iload      = '0;
    dload      = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    live_req   = 1'b0;
    is_write   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|dreq) begin
          gnt_data_d = 1'b1;
          gnt_cpu_d  = rr_pick(dreq, rr_ptr_q);
          state_d    = XFER;
        end else if (|iREN) begin
          gnt_data_d = 1'b0;
          gnt_cpu_d  = rr_pick(iREN, rr_ptr_q);
          state_d    = XFER;
        end
      end
      XFER: begin
        if (gnt_data_q) begin
          live_req = dreq[gnt_cpu_q];
          is_write = dWEN[gnt_cpu_q];
        end else begin
          live_req = iREN[gnt_cpu_q];
        end
        // A withdrawn request is an abort: no wait pulse, arbitration pointer untouched.
        if (!live_req) begin
          state_d = IDLE;
        end else begin
          ramWEN  = is_write;
          ramREN  = !is_write;
          ramaddr = gnt_data_q ? daddr[int'(gnt_cpu_q)*WORD_W +: WORD_W]
                               : iaddr[int'(gnt_cpu_q)*WORD_W +: WORD_W];
          if (is_write) ramstore = dstore[int'(gnt_cpu_q)*WORD_W +: WORD_W];
          if (ramstate == RAM_ACCESS) begin
            state_d  = IDLE;
            rr_ptr_d = CW'((int'(gnt_cpu_q) + 1) % NCPU);
            if (gnt_data_q) begin
              dwait[gnt_cpu_q] = 1'b0;
              if (!is_write) dload[int'(gnt_cpu_q)*WORD_W +: WORD_W] = ramload;
            end else begin
              iwait[gnt_cpu_q] = 1'b0;
              iload[int'(gnt_cpu_q)*WORD_W +: WORD_W] = ramload;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      gnt_cpu_q  <= '0;
      gnt_data_q <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_cpu_q  <= gnt_cpu_d;
      gnt_data_q <= gnt_data_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

`ifdef ARB_STATS_EN
  localparam logic [1:0] RAM_ERROR = 2'd3;

  logic [NCPU*16-1:0] grant_cnt_q, grant_cnt_d;
  logic [15:0]        err_cnt_q, err_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (state_q == XFER && live_req) begin
      if (ramstate == RAM_ACCESS && grant_cnt_q[int'(gnt_cpu_q)*16 +: 16] != 16'hFFFF)
        grant_cnt_d[int'(gnt_cpu_q)*16 +: 16] = grant_cnt_q[int'(gnt_cpu_q)*16 +: 16] + 16'd1;
      if (ramstate == RAM_ERROR && err_cnt_q != 16'hFFFF)
        err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      grant_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl: a transaction-level model checks every cycle, literal checks pin key scenarios.
module tb_cache_mem_ctrl;
  localparam int NCPU = 2;
  localparam int W    = 32;

  logic                CLK = 1'b0;
  logic                nRST = 1'b0;
  logic [NCPU-1:0]     iREN = '0, dREN = '0, dWEN = '0;
  logic [NCPU*W-1:0]   iaddr = '0, daddr = '0, dstore = '0;
  logic [NCPU-1:0]     iwait, dwait;
  logic [NCPU*W-1:0]   iload, dload;
  logic                ramREN, ramWEN;
  logic [W-1:0]        ramaddr, ramstore;
  logic [W-1:0]        ramload = '0;
  logic [1:0]          ramstate = 2'd0;
`ifdef ARB_STATS_EN
  logic [NCPU*16-1:0]  grant_cnt;
  logic [15:0]         err_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int log_q[$];

  always #5 CLK = ~CLK;

  cache_mem_ctrl #(.NCPU(NCPU), .WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload),
`ifdef ARB_STATS_EN
    .grant_cnt(grant_cnt), .err_cnt(err_cnt),
`endif
    .ramstate(ramstate)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic string log_str();
    string s;
    s = "";
    foreach (log_q[i]) s = {s, $sformatf("%s%0d ", (log_q[i] >= 4) ? "d" : "i", log_q[i] % 4)};
    return s;
  endfunction

  task automatic chk_log(input string name, input string exp);
    string act;
    act = log_str();
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
    end
  endtask

  // Model: one transaction in service at a time; who/kind chosen when the port is free.
  bit   m_busy, m_data;
  int   m_cpu, m_rr, m_ecnt, c;
  int   m_gcnt[NCPU];
  bit   mlive, mwr;
  logic [NCPU-1:0]   e_iw, e_dw;
  logic [NCPU*W-1:0] e_il, e_dl;
  logic              e_ren, e_wen;
  logic [W-1:0]      e_addr, e_store;

  always @(negedge CLK) begin
    if (nRST) begin
      for (int k = 0; k < NCPU; k++) begin
        if (!dwait[k]) log_q.push_back(4 + k);
        if (!iwait[k]) log_q.push_back(k);
      end
`ifdef ARB_STATS_EN
      for (int k = 0; k < NCPU; k++)
        chk($sformatf("grant_cnt%0d", k), grant_cnt[k*16 +: 16], 16'(m_gcnt[k]));
      chk("err_cnt", err_cnt, 16'(m_ecnt));
`endif
    end
    e_iw = '1; e_dw = '1; e_il = '0; e_dl = '0;
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
    if (!nRST) begin
      m_busy = 0; m_data = 0; m_cpu = 0; m_rr = 0; m_ecnt = 0;
      foreach (m_gcnt[k]) m_gcnt[k] = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < NCPU && !m_busy; k++) begin
        c = (m_rr + k) % NCPU;
        if (dREN[c] || dWEN[c]) begin m_busy = 1; m_data = 1; m_cpu = c; end
      end
      for (int k = 0; k < NCPU && !m_busy; k++) begin
        c = (m_rr + k) % NCPU;
        if (iREN[c]) begin m_busy = 1; m_data = 0; m_cpu = c; end
      end
    end else begin
      c     = m_cpu;
      mlive = m_data ? (dREN[c] || dWEN[c]) : iREN[c];
      mwr   = m_data && dWEN[c];
      if (!mlive) begin
        m_busy = 0;
      end else begin
        e_ren   = !mwr;
        e_wen   = mwr;
        e_addr  = m_data ? daddr[c*W +: W] : iaddr[c*W +: W];
        e_store = mwr ? dstore[c*W +: W] : '0;
        if (ramstate == 2'd2) begin
          if (m_data) begin
            e_dw[c] = 1'b0;
            if (!mwr) e_dl[c*W +: W] = ramload;
          end else begin
            e_iw[c] = 1'b0;
            e_il[c*W +: W] = ramload;
          end
          if (m_gcnt[c] < 65535) m_gcnt[c]++;
          m_rr   = (c + 1) % NCPU;
          m_busy = 0;
        end else if (ramstate == 2'd3 && m_ecnt < 65535) begin
          m_ecnt++;
        end
      end
    end
    chk("iwait", iwait, e_iw);
    chk("dwait", dwait, e_dw);
    chk("iload", iload, e_il);
    chk("dload", dload, e_dl);
    chk("ram_port", {ramREN, ramWEN, ramaddr, ramstore}, {e_ren, e_wen, e_addr, e_store});
  end

  task automatic mid(); @(negedge CLK); #1; endtask
  task automatic drv(); @(posedge CLK); #1; endtask
  task automatic run(input int n); repeat (n) begin mid(); drv(); end endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset and idle
    repeat (3) mid();
    chk("rst_iwait", iwait, 2'b11);
    chk("rst_dwait", dwait, 2'b11);
    chk("rst_en", {ramREN, ramWEN}, 2'b00);
    drv(); nRST = 1'b1;
    repeat (4) mid();
    chk("idle_en", {ramREN, ramWEN}, 2'b00);
    chk("idle_waits", {iwait, dwait}, 4'hF);

    // Single read with two BUSY cycles
    drv(); log_q.delete();
    dREN[0] = 1'b1; daddr[31:0] = 32'h100; ramstate = 2'd1; ramload = 32'hDEADBEEF;
    mid();
    drv(); mid();
    chk("rd_ren", ramREN, 1'b1);
    chk("rd_addr", ramaddr, 32'h100);
    chk("rd_wait_busy1", dwait, 2'b11);
    drv(); mid();
    chk("rd_wait_busy2", dwait, 2'b11);
    drv(); ramstate = 2'd2; mid();
    chk("rd_wait_low", dwait, 2'b10);
    chk("rd_dload", dload[31:0], 32'hDEADBEEF);
    drv(); dREN = '0; ramstate = 2'd1; mid();
    chk("rd_wait_back", dwait, 2'b11);
    chk_log("rd_pulses", "d0 ");

    // Data write beats a simultaneous instruction read
    drv(); log_q.delete();
    ramstate = 2'd2; ramload = 32'hCAFE0001;
    iREN[0] = 1'b1; iaddr[31:0] = 32'h40;
    dWEN[1] = 1'b1; daddr[63:32] = 32'h200; dstore[63:32] = 32'h1234;
    mid();
    chk("pri_idle", {iwait, dwait}, 4'hF);
    drv(); mid();
    chk("pri_wr_wait", dwait, 2'b01);
    chk("pri_wr_en", {ramREN, ramWEN}, 2'b01);
    chk("pri_wr_store", ramstore, 32'h1234);
    chk("pri_wr_addr", ramaddr, 32'h200);
    chk("pri_iwait_held", iwait, 2'b11);
    drv(); dWEN = '0; dstore = '0; mid();
    drv(); mid();
    chk("pri_rd_wait", iwait, 2'b10);
    chk("pri_iload", iload[31:0], 32'hCAFE0001);
    chk("pri_rd_addr", ramaddr, 32'h40);
    drv(); iREN = '0; mid();
    chk_log("pri_order", "d1 i0 ");

    // Round-robin with both cores holding dREN (pointer now at cpu1)
    drv(); log_q.delete();
    dREN = 2'b11; daddr = {32'h2000, 32'h1000}; ramstate = 2'd2;
    for (int k = 0; k < 12; k++) begin
      ramload = 32'hA000_0000 + 32'(k);
      mid(); drv();
    end
    dREN = '0; mid();
    chk_log("rr_alternate", "d1 d0 d1 d0 d1 d0 ");

    // ERROR retries then abort
    drv(); log_q.delete();
    dREN[0] = 1'b1; daddr[31:0] = 32'h300; ramstate = 2'd3;
    mid();
    for (int k = 0; k < 3; k++) begin
      drv(); mid();
      chk("err_wait", dwait, 2'b11);
      chk("err_en", {ramREN, ramWEN}, 2'b10);
    end
    drv(); dREN = '0; ramstate = 2'd0; #1;
    chk("abort_en", {ramREN, ramWEN}, 2'b00);
    mid();
    chk("abort_waits", {iwait, dwait}, 4'hF);
    drv(); mid();
    chk_log("abort_nopulse", "");

    // Abort must not advance the pointer: cpu1 still goes first
    drv(); log_q.delete();
    dREN = 2'b11; ramstate = 2'd2;
    run(2);
    dREN = '0; mid();
    chk_log("abort_rr", "d1 ");

    // dREN and dWEN together is a write with no load data
    drv(); log_q.delete();
    dREN[0] = 1'b1; dWEN[0] = 1'b1; daddr[31:0] = 32'h500; dstore[31:0] = 32'h55; ramload = 32'h77;
    mid(); drv(); mid();
    chk("wr_rd_en", {ramREN, ramWEN}, 2'b01);
    chk("wr_rd_dload", dload[31:0], 32'h0);
    chk("wr_rd_store", ramstore, 32'h55);
    drv(); dREN = '0; dWEN = '0; dstore = '0; mid();

    // Back-to-back instruction reads from one core
    drv(); log_q.delete();
    iREN[1] = 1'b1; iaddr[63:32] = 32'h80; ramload = 32'h1111_2222;
    run(6);
    iREN = '0; mid();
    chk_log("b2b_same_core", "i1 i1 i1 ");

    // Asynchronous reset in the middle of a transfer
    drv(); dREN[1] = 1'b1; daddr[63:32] = 32'h600; ramstate = 2'd1;
    mid(); drv(); mid();
    chk("xfer_before_rst", ramREN, 1'b1);
    #2; nRST = 1'b0; #1;
    chk("rst_mid_en", {ramREN, ramWEN}, 2'b00);
    chk("rst_mid_waits", {iwait, dwait}, 4'hF);
    mid();
    drv(); nRST = 1'b1; dREN = '0;

    // ERROR cycles then five completed cpu1 transfers
    drv(); log_q.delete();
    dREN[1] = 1'b1; daddr[63:32] = 32'h700; ramstate = 2'd3;
    mid(); drv(); mid(); drv(); mid();
    drv(); ramstate = 2'd2;
    run(9);
    dREN = '0; mid();
    chk_log("stats_seq", "d1 d1 d1 d1 d1 ");
`ifdef ARB_STATS_EN
    chk("stats_grant", grant_cnt, {16'd5, 16'd0});
    chk("stats_err", err_cnt, 16'd2);
`endif

    repeat (2) mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
